seg7_pattern_decoder: RTL and testbench



---
 rtl/seg7_pattern_decoder.sv | 157 +++++++++++++++
 tb/tb_seg7_pattern_decoder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_pattern_decoder.sv
// Recovers the hex digit shown on seven segment lines: the lines are synchronized,
// debounced by a stability counter, and a steady pattern is decoded and committed once.
module seg7_pattern_decoder #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Seg_a,
  input  logic       i_Seg_b,
  input  logic       i_Seg_c,
  input  logic       i_Seg_d,
  input  logic       i_Seg_e,
  input  logic       i_Seg_f,
  input  logic       i_Seg_g,
  output logic [3:0] o_binary,
  output logic       o_valid,
  output logic       o_blank,
  output logic       o_error
);

  typedef enum logic {
    TRACK  = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  // Returns {hit, value} for a segment pattern ordered abcdefg (a = MSB).
  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    case (pat)
      7'b1111110: decode_seg = {1'b1, 4'h0};
      7'b0110000: decode_seg = {1'b1, 4'h1};
      7'b1101101: decode_seg = {1'b1, 4'h2};
      7'b1111001: decode_seg = {1'b1, 4'h3};
      7'b0110011: decode_seg = {1'b1, 4'h4};
      7'b1011011: decode_seg = {1'b1, 4'h5};
      7'b1011111: decode_seg = {1'b1, 4'h6};
      7'b1110000: decode_seg = {1'b1, 4'h7};
      7'b1111111: decode_seg = {1'b1, 4'h8};
      7'b1111011: decode_seg = {1'b1, 4'h9};
      7'b1110111: decode_seg = {1'b1, 4'hA};
      7'b0011111: decode_seg = {1'b1, 4'hB};
      7'b1001110: decode_seg = {1'b1, 4'hC};
      7'b0111101: decode_seg = {1'b1, 4'hD};
      7'b1001111: decode_seg = {1'b1, 4'hE};
      7'b1000111: decode_seg = {1'b1, 4'hF};
      default:    decode_seg = {1'b0, 4'h0};
    endcase
  endfunction

  logic [6:0] seg_raw_s;
  logic [6:0] seg_cond_s;
  logic [6:0] sync1_r;
  logic [6:0] sync2_r;
  logic [6:0] cand_r;
  logic [6:0] last_r;
  logic [7:0] cnt_r;
  state_t     state_r;
  logic       first_r;
  logic [3:0] binary_r;
  logic       valid_r;
  logic       blank_r;
  logic       error_r;

  logic [6:0] cand_nxt_s;
  logic [7:0] cnt_nxt_s;
  state_t     state_nxt_s;
  logic       commit_s;
  logic       announce_s;
  logic [4:0] dec_s;
  logic       blank_s;
  logic       error_s;

  assign seg_raw_s = {i_Seg_a, i_Seg_b, i_Seg_c, i_Seg_d, i_Seg_e, i_Seg_f, i_Seg_g};

  // Optional polarity flip ahead of the synchronizer.
  always_comb begin
    seg_cond_s = seg_raw_s;
    if (SEG_ACTIVE_LOW) begin
      seg_cond_s = ~seg_raw_s;
    end else begin
      seg_cond_s = seg_raw_s;
    end
  end

  assign dec_s   = decode_seg(cand_r);
  assign blank_s = (cand_r == 7'b0000000);
  assign error_s = !dec_s[4] && !blank_s;

  // Stability tracking: any change restarts the count; a full count commits once.
  always_comb begin
    cand_nxt_s  = cand_r;
    cnt_nxt_s   = cnt_r;
    state_nxt_s = state_r;
    commit_s    = 1'b0;
    if (sync2_r != cand_r) begin
      cand_nxt_s  = sync2_r;
      cnt_nxt_s   = 8'd0;
      state_nxt_s = TRACK;
    end else begin
      case (state_r)
        TRACK: begin
          if (cnt_r == CNT_LAST) begin
            commit_s    = 1'b1;
            state_nxt_s = LOCKED;
          end else begin
            cnt_nxt_s = cnt_r + 8'd1;
          end
        end
        LOCKED:  state_nxt_s = LOCKED;
        default: state_nxt_s = TRACK;
      endcase
    end
    // A glitch that settles back onto the committed pattern stays silent.
    announce_s = commit_s && (first_r || (cand_r != last_r));
  end

  // Synchronizer, tracker state and registered outputs.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      sync1_r  <= 7'd0;
      sync2_r  <= 7'd0;
      cand_r   <= 7'd0;
      last_r   <= 7'd0;
      cnt_r    <= 8'd0;
      state_r  <= TRACK;
      first_r  <= 1'b1;
      binary_r <= 4'h0;
      valid_r  <= 1'b0;
      blank_r  <= 1'b0;
      error_r  <= 1'b0;
    end else begin
      sync1_r <= seg_cond_s;
      sync2_r <= sync1_r;
      cand_r  <= cand_nxt_s;
      cnt_r   <= cnt_nxt_s;
      state_r <= state_nxt_s;
      valid_r <= announce_s;
      if (commit_s) begin
        blank_r <= blank_s;
        error_r <= error_s;
        first_r <= 1'b0;
        last_r  <= cand_r;
        if (dec_s[4]) begin
          binary_r <= dec_s[3:0];
        end
      end
    end
  end

  assign o_binary = binary_r;
  assign o_valid  = valid_r;
  assign o_blank  = blank_r;
  assign o_error  = error_r;

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// Bench for seg7_pattern_decoder: a streak-based reference model checked every cycle,
// plus directed literal checks on commit counts, latency and decoded values.
module tb_seg7_pattern_decoder;

  localparam int N = 4;

  localparam logic [6:0] TBL [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  logic       clk;
  logic       rst_n;
  logic [6:0] seg;

  logic [3:0] d_binary, al_binary, n1_binary;
  logic       d_valid, al_valid, n1_valid;
  logic       d_blank, al_blank, n1_blank;
  logic       d_error, al_error, n1_error;

  int checks = 0;
  int failures = 0;
  int ecnt = 0;
  int vtot = 0, al_vtot = 0, n1_vtot = 0;
  int last_v_edge = 0, n1_last_v_edge = 0;
  int mark = 0, vmark = 0, al_vmark = 0;

  // Reference model state
  logic [6:0] m_d1, m_d2, m_prev, m_last;
  int         m_streak;
  bit         m_first;
  logic [3:0] e_binary;
  logic       e_valid, e_blank, e_error;

  seg7_pattern_decoder dut (
    .i_Clk(clk), .i_Rst_L(rst_n),
    .i_Seg_a(seg[6]), .i_Seg_b(seg[5]), .i_Seg_c(seg[4]), .i_Seg_d(seg[3]),
    .i_Seg_e(seg[2]), .i_Seg_f(seg[1]), .i_Seg_g(seg[0]),
    .o_binary(d_binary), .o_valid(d_valid), .o_blank(d_blank), .o_error(d_error)
  );

  seg7_pattern_decoder #(.STABLE_CYCLES(4), .SEG_ACTIVE_LOW(1'b1)) dut_al (
    .i_Clk(clk), .i_Rst_L(rst_n),
    .i_Seg_a(seg[6]), .i_Seg_b(seg[5]), .i_Seg_c(seg[4]), .i_Seg_d(seg[3]),
    .i_Seg_e(seg[2]), .i_Seg_f(seg[1]), .i_Seg_g(seg[0]),
    .o_binary(al_binary), .o_valid(al_valid), .o_blank(al_blank), .o_error(al_error)
  );

  seg7_pattern_decoder #(.STABLE_CYCLES(1), .SEG_ACTIVE_LOW(1'b0)) dut_n1 (
    .i_Clk(clk), .i_Rst_L(rst_n),
    .i_Seg_a(seg[6]), .i_Seg_b(seg[5]), .i_Seg_c(seg[4]), .i_Seg_d(seg[3]),
    .i_Seg_e(seg[2]), .i_Seg_f(seg[1]), .i_Seg_g(seg[0]),
    .o_binary(n1_binary), .o_valid(n1_valid), .o_blank(n1_blank), .o_error(n1_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  // A pattern is committed when it has been seen on N+1 consecutive edges
  // (the edge it first appears plus N confirming edges); reset counts as seeing blank.
  task automatic model_step();
    logic [6:0] p;
    bit hit;
    int idx;
    if (!rst_n) begin
      m_d1 = '0; m_d2 = '0; m_prev = '0; m_last = '0;
      m_streak = 1; m_first = 1'b1;
      e_binary = 4'h0; e_valid = 1'b0; e_blank = 1'b0; e_error = 1'b0;
    end else begin
      p = m_d2;
      m_d2 = m_d1;
      m_d1 = seg;
      if (p == m_prev) m_streak++;
      else begin m_streak = 1; m_prev = p; end
      e_valid = 1'b0;
      if (m_streak == N + 1) begin
        hit = 1'b0; idx = 0;
        for (int k = 0; k < 16; k++) if (TBL[k] == p) begin hit = 1'b1; idx = k; end
        e_valid = m_first || (p != m_last);
        e_blank = (p == 7'd0);
        e_error = !hit && (p != 7'd0);
        if (hit) e_binary = 4'(idx);
        m_first = 1'b0;
        m_last = p;
      end
    end
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      ecnt++;
      model_step();
      chk("cyc_binary", int'(d_binary), int'(e_binary));
      chk("cyc_valid", int'(d_valid), int'(e_valid));
      chk("cyc_blank", int'(d_blank), int'(e_blank));
      chk("cyc_error", int'(d_error), int'(e_error));
      if (d_valid)  begin vtot++; last_v_edge = ecnt; end
      if (al_valid) al_vtot++;
      if (n1_valid) begin n1_vtot++; n1_last_v_edge = ecnt; end
    end
  end

  task automatic hold(input logic [6:0] v, input int cycles);
    seg = v;
    mark = ecnt;
    vmark = vtot;
    al_vmark = al_vtot;
    repeat (cycles) @(negedge clk);
    #1;
  endtask

  initial begin
    int snap;
    rst_n = 1'b0;
    seg = 7'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_binary", int'(d_binary), 0);
    chk("rst_valid", int'(d_valid), 0);
    chk("rst_blank", int'(d_blank), 0);
    chk("rst_error", int'(d_error), 0);

    // Blank held after reset: committed once, counter starts on the reset-loaded blank.
    rst_n = 1'b1;
    hold(7'b0000000, 10);
    chk("blank_valids", vtot - vmark, 1);
    chk("blank_latency", last_v_edge - mark, 4);
    chk("blank_flag", int'(d_blank), 1);
    chk("blank_binary", int'(d_binary), 0);

    for (int i = 0; i < 16; i++) begin
      hold(TBL[i], 12);
      chk("tbl_valids", vtot - vmark, 1);
      chk("tbl_latency", last_v_edge - mark, 7);
      chk("tbl_binary", int'(d_binary), i);
      chk("tbl_error", int'(d_error), 0);
    end

    // Glitches away from 2 and back must not strobe.
    hold(7'b1101101, 12);
    chk("two_binary", int'(d_binary), 2);
    snap = vtot;
    hold(7'b1111111, 1);
    hold(7'b1101101, 5);
    hold(7'b1111111, 3);
    hold(7'b1101101, 12);
    chk("glitch_valids", vtot - snap, 0);
    chk("glitch_binary", int'(d_binary), 2);

    // Invalid pattern keeps the last good value.
    hold(7'b1011011, 12);
    chk("five_binary", int'(d_binary), 5);
    hold(7'b1010101, 10);
    chk("inv_valids", vtot - vmark, 1);
    chk("inv_error", int'(d_error), 1);
    chk("inv_blank", int'(d_blank), 0);
    chk("inv_binary", int'(d_binary), 5);
    hold(7'b1111011, 12);
    chk("nine_error", int'(d_error), 0);
    chk("nine_binary", int'(d_binary), 9);

    // Reset during a pending commit of 7.
    hold(7'b1110000, 5);
    snap = vtot;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("abort_valids", vtot - snap, 0);
    chk("abort_binary", int'(d_binary), 0);
    chk("abort_blank", int'(d_blank), 0);
    chk("abort_error", int'(d_error), 0);
    rst_n = 1'b1;
    hold(7'b1110000, 10);
    chk("seven_valids", vtot - vmark, 1);
    chk("seven_latency", last_v_edge - mark, 7);
    chk("seven_binary", int'(d_binary), 7);

    // Inverted 3 for the active-low instance; single-cycle stability instance latency.
    hold(7'b0000110, 12);
    chk("al_valids", al_vtot - al_vmark, 1);
    chk("al_binary", int'(al_binary), 3);
    chk("al_error", int'(al_error), 0);
    chk("n1_latency", n1_last_v_edge - mark, 4);
    chk("n1_error", int'(n1_error), 1);
    chk("main_inv_error", int'(d_error), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
